// File: rtl/urv_shifter_pipe_pkg.sv
// Function codes and shift-mode encodings shared by the shifter pipe and its users.
`ifndef FUNC_SL
`define FUNC_SL 3'b001
`endif
`ifndef FUNC_SR
`define FUNC_SR 3'b101
`endif
`ifndef SHIFT_MODE_ROT
`define SHIFT_MODE_ROT 2'b10
`endif

package urv_shifter_pipe_pkg;
  localparam logic [2:0] FN_SL = `FUNC_SL;
  localparam logic [2:0] FN_SR = `FUNC_SR;

  // Mode carried in the stage registers; rotate wraps, arith sign-fills.
  typedef enum logic [1:0] {
    MODE_LOGIC = 2'b00,
    MODE_ARITH = 2'b01,
    MODE_ROT   = `SHIFT_MODE_ROT
  } shmode_e;
endpackage

// File: rtl/urv_shift_stage.sv
// One barrel-shifter rank: conditional right shift by AMT with fill or wrap.
module urv_shift_stage #(
  parameter int WIDTH = 32,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  input  logic             wrap_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = {{AMT{fill_i}}, d_i[WIDTH-1:AMT]};
    if (wrap_i) shifted = {d_i[AMT-1:0], d_i[WIDTH-1:AMT]};
    q_o = en_i ? shifted : d_i;
  end
endmodule

// File: rtl/urv_shifter_pipe.sv
// Pipelined shift/rotate unit; left ops run as reverse -> right op -> reverse.
module urv_shifter_pipe
  import urv_shifter_pipe_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     x_stall_i,
  input  logic                     x_kill_i,
  input  logic                     d_valid_i,
  input  logic                     d_is_shift_i,
  input  logic [WIDTH-1:0]         d_rs1_i,
  input  logic [$clog2(WIDTH)-1:0] d_shamt_i,
  input  logic [2:0]               d_fun_i,
  input  logic                     d_shifter_sign_i,
  input  logic                     d_rotate_i,
  output logic [WIDTH-1:0]         w_rd_o,
  output logic                     w_valid_o
);
  localparam int SHW = $clog2(WIDTH);
  // Lowest shamt bit resolved ahead of the stage-1 register.
  localparam int LO  = (PIPE_STAGES == 2) ? 3 : 0;

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  logic             acc, left, fill;
  shmode_e          mode;
  logic [WIDTH-1:0] opnd, res;
  logic             res_left, res_vld;
  logic [WIDTH-1:0] ch_hi [LO:SHW];
  logic [WIDTH-1:0] w_rd_q, w_rd_d;
  logic             w_valid_q, w_valid_d;

  always_comb begin
    acc  = d_valid_i & d_is_shift_i;
    left = (d_fun_i == FN_SL);
    mode = d_rotate_i ? MODE_ROT : ((!left && d_shifter_sign_i) ? MODE_ARITH : MODE_LOGIC);
    fill = (mode == MODE_ARITH) & d_rs1_i[WIDTH-1];
    opnd = left ? bitrev(d_rs1_i) : d_rs1_i;
  end

  assign ch_hi[SHW] = opnd;

  for (genvar k = LO; k < SHW; k++) begin : g_hi
    urv_shift_stage #(.WIDTH(WIDTH), .AMT(1 << k)) u_stage (
      .d_i    (ch_hi[k+1]),
      .en_i   (d_shamt_i[k]),
      .wrap_i (mode == MODE_ROT),
      .fill_i (fill),
      .q_o    (ch_hi[k])
    );
  end

  if (PIPE_STAGES == 2) begin : g_s1
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       shlo_q, shlo_d;
    shmode_e          mode_q, mode_d;
    logic             fill_q, fill_d, left_q, left_d, vld_q, vld_d;
    logic [WIDTH-1:0] ch_lo [0:3];

    always_comb begin
      data_d = data_q;
      shlo_d = shlo_q;
      mode_d = mode_q;
      fill_d = fill_q;
      left_d = left_q;
      vld_d  = vld_q;
      if (!x_stall_i) begin
        data_d = ch_hi[LO];
        shlo_d = d_shamt_i[2:0];
        mode_d = mode;
        fill_d = fill;
        left_d = left;
        vld_d  = acc;
      end
      if (x_kill_i) vld_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        data_q <= '0;
        shlo_q <= '0;
        mode_q <= MODE_LOGIC;
        fill_q <= 1'b0;
        left_q <= 1'b0;
        vld_q  <= 1'b0;
      end else begin
        data_q <= data_d;
        shlo_q <= shlo_d;
        mode_q <= mode_d;
        fill_q <= fill_d;
        left_q <= left_d;
        vld_q  <= vld_d;
      end
    end

    assign ch_lo[3] = data_q;

    for (genvar k = 0; k < 3; k++) begin : g_lo
      urv_shift_stage #(.WIDTH(WIDTH), .AMT(1 << k)) u_stage (
        .d_i    (ch_lo[k+1]),
        .en_i   (shlo_q[k]),
        .wrap_i (mode_q == MODE_ROT),
        .fill_i (fill_q),
        .q_o    (ch_lo[k])
      );
    end

    assign res      = ch_lo[0];
    assign res_left = left_q;
    assign res_vld  = vld_q;
  end else begin : g_s0
    assign res      = ch_hi[0];
    assign res_left = left;
    assign res_vld  = acc;
  end

  // Result only loads with a live op, so w_rd_o holds while w_valid_o is low.
  always_comb begin
    w_rd_d    = w_rd_q;
    w_valid_d = w_valid_q;
    if (!x_stall_i) begin
      w_valid_d = res_vld;
      if (res_vld) w_rd_d = res_left ? bitrev(res) : res;
    end
    if (x_kill_i) begin
      w_valid_d = 1'b0;
      w_rd_d    = w_rd_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_rd_q    <= '0;
      w_valid_q <= 1'b0;
    end else begin
      w_rd_q    <= w_rd_d;
      w_valid_q <= w_valid_d;
    end
  end

  assign w_rd_o    = w_rd_q;
  assign w_valid_o = w_valid_q;
endmodule

// File: tb/tb_urv_shifter_pipe.sv
// Bench: 32-bit/2-stage and 64-bit/1-stage shifters against a queue-based model.
module tb_urv_shifter_pipe;
  import urv_shifter_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, kill, dv, dsh, sgn, rot;
  logic [63:0] rs1;
  logic [5:0]  shamt;
  logic [2:0]  fun;
  logic [31:0] w_rd32;
  logic [63:0] w_rd64;
  logic        w_v32, w_v64;

  always #5 clk = ~clk;

  urv_shifter_pipe #(.WIDTH(32), .PIPE_STAGES(2)) dut32 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(stall), .x_kill_i(kill),
    .d_valid_i(dv), .d_is_shift_i(dsh), .d_rs1_i(rs1[31:0]), .d_shamt_i(shamt[4:0]),
    .d_fun_i(fun), .d_shifter_sign_i(sgn), .d_rotate_i(rot),
    .w_rd_o(w_rd32), .w_valid_o(w_v32)
  );

  urv_shifter_pipe #(.WIDTH(64), .PIPE_STAGES(1)) dut64 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(stall), .x_kill_i(kill),
    .d_valid_i(dv), .d_is_shift_i(dsh), .d_rs1_i(rs1), .d_shamt_i(shamt),
    .d_fun_i(fun), .d_shifter_sign_i(sgn), .d_rotate_i(rot),
    .w_rd_o(w_rd64), .w_valid_o(w_v64)
  );

  typedef struct {
    int          d;
    logic [63:0] val;
    int          rem;
  } ent_t;

  ent_t        pq[$];
  logic        exp_v  [2];
  logic [63:0] exp_rd [2];
  int          nvec = 0;
  int          nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  // ISA-level result: plain shifts on a zero-extended 64-bit value, masked to w.
  function automatic logic [63:0] ref_op(input int w, input logic [63:0] a_in, input int sh,
                                         input logic [2:0] fn, input logic sg, input logic rt);
    logic [63:0]        mask, a, r;
    logic signed [63:0] s;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a = a_in & mask;
    s = (w == 32) ? {{32{a[31]}}, a[31:0]} : a;
    if (rt)               r = (fn == FN_SL) ? ((a << sh) | (a >> (w - sh))) : ((a >> sh) | (a << (w - sh)));
    else if (fn == FN_SL) r = a << sh;
    else if (sg)          r = s >>> sh;
    else                  r = a >> sh;
    return r & mask;
  endfunction

  task automatic model_edge(input logic acc, input logic [63:0] a, input int sh,
                            input logic [2:0] fn, input logic sg, input logic rt);
    ent_t nq[$];
    for (int d = 0; d < 2; d++) begin
      int w;
      int lat;
      w   = (d == 0) ? 32 : 64;
      lat = (d == 0) ? 2 : 1;
      if (rst) begin
        exp_v[d]  = 1'b0;
        exp_rd[d] = '0;
      end else if (kill) begin
        exp_v[d] = 1'b0;
      end else if (!stall) begin
        exp_v[d] = 1'b0;
        if (acc) pq.push_back('{d, ref_op(w, a, sh % w, fn, sg, rt), lat});
      end
    end
    nq = {};
    foreach (pq[i]) begin
      ent_t e;
      e = pq[i];
      if (rst || kill) continue;
      if (!stall) begin
        e.rem--;
        if (e.rem == 0) begin
          exp_v[e.d]  = 1'b1;
          exp_rd[e.d] = e.val;
          continue;
        end
      end
      nq.push_back(e);
    end
    pq = nq;
  endtask

  task automatic cyc(input logic v, input logic ish, input logic [63:0] a, input int sh,
                     input logic [2:0] fn, input logic sg, input logic rt,
                     input logic stl, input logic kl, input logic rs);
    dv = v; dsh = ish; rs1 = a; shamt = 6'(sh); fun = fn; sgn = sg; rot = rt;
    stall = stl; kill = kl; rst = rs;
    @(posedge clk);
    model_edge(v && ish, a, sh, fn, sg, rt);
    #1;
    chk("valid32", {63'b0, w_v32}, {63'b0, exp_v[0]});
    chk("rd32",    {32'b0, w_rd32}, exp_rd[0]);
    chk("valid64", {63'b0, w_v64}, {63'b0, exp_v[1]});
    chk("rd64",    w_rd64, exp_rd[1]);
  endtask

  task automatic idle(input logic stl);
    cyc(1'b0, 1'b0, 64'h0, 0, FN_SR, 1'b0, 1'b0, stl, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 64'h0, 0, FN_SR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_v32", {63'b0, w_v32}, 64'h0);
    chk("rst_rd32", {32'b0, w_rd32}, 64'h0);
    idle(1'b0);

    // SRA with exact two-cycle latency
    cyc(1'b1, 1'b1, 64'h8000_0000, 4, FN_SR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sra_early", {63'b0, w_v32}, 64'h0);
    idle(1'b0);
    chk("sra_v", {63'b0, w_v32}, 64'h1);
    chk("sra_rd", {32'b0, w_rd32}, 64'hF800_0000);
    idle(1'b0);

    // rotates back-to-back
    cyc(1'b1, 1'b1, 64'h8000_0001, 1, FN_SL, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 64'h0000_0001, 1, FN_SR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rol32", {32'b0, w_rd32}, 64'h0000_0003);
    idle(1'b0);
    chk("ror32", {32'b0, w_rd32}, 64'h8000_0000);

    // 64-bit edges of the shift range
    cyc(1'b1, 1'b1, 64'h1, 63, FN_SL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sll64", w_rd64, 64'h8000_0000_0000_0000);
    cyc(1'b1, 1'b1, 64'h8000_0000_0000_0000, 63, FN_SR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("srl64", w_rd64, 64'h1);
    idle(1'b0); idle(1'b0);

    // back-to-back stream with a 3-cycle stall in the middle
    for (int i = 0; i < 6; i++) begin
      if (i == 3) for (int j = 0; j < 3; j++)
        cyc(1'b1, 1'b1, 64'hDEAD_BEEF, 7, FN_SR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, {$urandom, $urandom}, i * 5, (i % 2) ? FN_SL : FN_SR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    idle(1'b0); idle(1'b0);

    // kill with stall while two ops are in flight
    cyc(1'b1, 1'b1, 64'h1234_5678, 3, FN_SL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 64'h8765_4321, 2, FN_SR, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    chk("kill_v32", {63'b0, w_v32}, 64'h0);
    idle(1'b0);
    chk("kill_v32b", {63'b0, w_v32}, 64'h0);
    cyc(1'b1, 1'b1, 64'h0F, 4, FN_SL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("after_kill", {32'b0, w_rd32}, 64'hF0);

    // reset one cycle after accept
    cyc(1'b1, 1'b1, 64'hFFFF_FFFF, 1, FN_SR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 64'h0, 0, FN_SR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_v", {63'b0, w_v32}, 64'h0);
    chk("rst_mid_rd", {32'b0, w_rd32}, 64'h0);
    for (int i = 0; i < 3; i++) idle(1'b0);

    // randomized traffic, shift amounts biased toward the range edges
    for (int i = 0; i < 500; i++) begin
      int sh;
      case ($urandom_range(0, 4))
        0:       sh = 0;
        1:       sh = 31;
        2:       sh = 32;
        3:       sh = 63;
        default: sh = $urandom_range(0, 63);
      endcase
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 9, {$urandom, $urandom}, sh,
          ($urandom_range(0, 2) == 0) ? FN_SL : (($urandom_range(0, 1) == 0) ? FN_SR : 3'($urandom)),
          1'($urandom), $urandom_range(0, 3) == 0,
          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1);
    end
    for (int i = 0; i < 3; i++) idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
